patgen: RTL and testbench
=========================

PATGEN -- requirements
Module: patgen

Interface
REQ-001 Parameter WIDTH, default 8, pattern length in bits (legal 2..64).
REQ-002 Parameter DIV_W, default 4, width of bit-period divider input.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 LOAD  input  1  capture PATTERN into internal pattern register.
REQ-006 PATTERN  input  WIDTH  pattern to transmit, MSB sent first.
REQ-007 START  input  1  begin transmission of stored pattern.
REQ-008 STOP  input  1  abort transmission.
REQ-009 REPEAT  input  1  1 = loop pattern continuously; 0 = one-shot.
REQ-010 DIV  input  DIV_W  bit period minus one, in CLK cycles.
REQ-011 bitstream  output  1  serial data, registered.
REQ-012 VALID  output  1  high while bitstream carries a pattern or parity bit.
REQ-013 BUSY  output  1  high in any state other than IDLE.
REQ-014 DONE  output  1  one-cycle pulse on normal one-shot completion.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, PAR (PAR present only per REQ-030).
REQ-016 LOAD in IDLE SHALL capture PATTERN at that edge; LOAD outside IDLE SHALL be ignored.
REQ-017 LOAD and START in the same IDLE cycle SHALL transmit the newly loaded PATTERN.
REQ-018 START in IDLE SHALL latch DIV and REPEAT and enter SHIFT next edge; bitstream = pattern[WIDTH-1], VALID = 1, BUSY = 1 that cycle.
REQ-019 START outside IDLE SHALL be ignored.
REQ-020 Each bit SHALL be held exactly DIV+1 cycles; DIV = 0 gives one bit per cycle.
REQ-021 Bit index SHALL decrement WIDTH-1 down to 0; after bit 0's period: PAR if enabled, else end-of-frame.
REQ-022 End-of-frame with latched REPEAT = 1 SHALL restart at pattern[WIDTH-1] with zero idle cycles; DONE not asserted.
REQ-023 End-of-frame with latched REPEAT = 0 SHALL return to IDLE; DONE = 1 for the first IDLE cycle only.
REQ-024 STOP while BUSY SHALL return to IDLE next edge; no DONE pulse; STOP has priority over frame end.
REQ-025 In IDLE: bitstream = 0, VALID = 0, BUSY = 0; STOP in IDLE has no effect.
REQ-026 REPEAT or DIV changes during transmission SHALL NOT affect the frame in progress; they take effect at the next START only.

Reset
REQ-027 RST SHALL force state IDLE, bitstream = 0, VALID = 0, BUSY = 0, DONE = 0, bit counter and divider counter to 0, immediately and independently of CLK.
REQ-028 Pattern register SHALL reset to all-zeros.
REQ-029 RST asserted mid-frame SHALL abort without DONE; after release, block accepts LOAD/START on the first CLK edge.

Configuration
REQ-030 Macro PATGEN_PARITY_EN defined: after bit 0, state PAR SHALL output even parity (XOR of all WIDTH pattern bits) for DIV+1 cycles with VALID = 1; frame length WIDTH+1 bits.
REQ-031 Macro PATGEN_PARITY_EN undefined: PAR state and parity logic SHALL be absent; frame length WIDTH bits.

Structure
REQ-032 Shared package patgen_pkg SHALL hold the state enumeration type and a function returning counter width clog2(WIDTH).
REQ-033 Sub-module patgen_div (DIV_W-bit down-counter producing a one-cycle bit-tick, reloaded with DIV on START and on each tick) SHALL be instantiated once.

Verification
REQ-034 RST mid-frame -> all outputs 0 asynchronously, before next CLK edge; DONE stays 0.
REQ-035 LOAD 8'b10001101, DIV=0, REPEAT=0, START -> bitstream 1,0,0,0,1,1,0,1 on 8 consecutive cycles, VALID high 8 cycles, DONE pulse on cycle 9.
REQ-036 Same pattern, DIV=2 -> each bit held 3 cycles, 24 VALID cycles, then DONE.
REQ-037 REPEAT=1, DIV=0 -> pattern repeats back-to-back 3 times with no gap; STOP at cycle 20 -> IDLE at cycle 21, no DONE.
REQ-038 PATGEN_PARITY_EN defined, pattern 8'b10001101 -> 9th bit = 0 (even parity of four 1s); pattern 8'b10001100 -> 9th bit = 1.
REQ-039 START and LOAD while BUSY -> ignored; frame in progress completes unchanged with original pattern.

Source files
------------

// File: rtl/patgen_pkg.sv
// Shared types and helpers for the pattern generator.
// Holds the FSM state enumeration and the bit-counter width function.
// Optional macro: PATGEN_PARITY_EN adds the PAR state.
package patgen_pkg;

`ifdef PATGEN_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  // Width of the bit-index counter: clog2(width), never below one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/patgen_div.sv
// Purpose : bit-period down-counter; emits a one-cycle tick every reload+1 enabled cycles.
// Latency : tick is combinational from the counter state; counter updates on rising clk.
// Backpr. : none; load has priority over counting and suppresses the tick.
// Ports   : clk, rst (async active-high), load/load_val (start of frame),
//           en (count while busy), reload_val (value restored on each tick), tick.
module patgen_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en && !load && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (cnt_q == '0) cnt_d = reload_val;
      else             cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/patgen.sv
// Purpose : serial pattern generator, MSB first, each bit held DIV+1 cycles, one-shot or looping.
// Latency : first bit appears on bitstream the cycle after the START edge; outputs registered.
// Backpr. : none; START/LOAD ignored while busy, STOP aborts at the next edge.
// Ports   : CLK, RST (async active-high), LOAD/PATTERN, START, STOP, REPEAT, DIV,
//           bitstream, VALID, BUSY, DONE.
// Optional macro: PATGEN_PARITY_EN appends an even-parity bit after bit 0.
module patgen
  import patgen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic             START,
  input  logic             STOP,
  input  logic             REPEAT,
  input  logic [DIV_W-1:0] DIV,
  output logic             bitstream,
  output logic             VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic             bs_q, bs_d;
  logic             done_q, done_d;
  logic             rep_q, rep_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic busy;
  logic start_ok;
  logic tick;
  logic eof;

  assign busy     = (state_q != IDLE);
  assign start_ok = (state_q == IDLE) && START;

  // Start loads the live DIV; every later tick reloads the value latched at start.
  patgen_div #(.DIV_W(DIV_W)) u_div (
    .clk        (CLK),
    .rst        (RST),
    .load       (start_ok),
    .load_val   (DIV),
    .en         (busy),
    .reload_val (div_q),
    .tick       (tick)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    bs_d    = bs_q;
    done_d  = 1'b0;
    rep_d   = rep_q;
    div_d   = div_q;
    eof     = 1'b0;

    case (state_q)
      IDLE: begin
        bs_d = 1'b0;
        if (LOAD) pat_d = PATTERN;
        if (START) begin
          state_d = SHIFT;
          bit_d   = LAST_IDX;
          rep_d   = REPEAT;
          div_d   = DIV;
          // A same-cycle LOAD must be visible in the very first bit.
          bs_d    = LOAD ? PATTERN[WIDTH-1] : pat_q[WIDTH-1];
        end
      end

      SHIFT: begin
        if (STOP) begin
          state_d = IDLE;
          bs_d    = 1'b0;
          bit_d   = '0;
        end else if (tick) begin
          if (bit_q != '0) begin
            bit_d = bit_q - ONE;
            bs_d  = pat_q[bit_d];
          end else begin
`ifdef PATGEN_PARITY_EN
            state_d = PAR;
            bs_d    = ^pat_q;
`else
            eof = 1'b1;
`endif
          end
        end
      end

`ifdef PATGEN_PARITY_EN
      PAR: begin
        if (STOP) begin
          state_d = IDLE;
          bs_d    = 1'b0;
          bit_d   = '0;
        end else if (tick) begin
          eof = 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        bs_d    = 1'b0;
        bit_d   = '0;
      end
    endcase

    // STOP is handled above, so eof only fires on an unaborted frame end.
    if (eof) begin
      if (rep_q) begin
        state_d = SHIFT;
        bit_d   = LAST_IDX;
        bs_d    = pat_q[WIDTH-1];
      end else begin
        state_d = IDLE;
        bit_d   = '0;
        bs_d    = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pat_q   <= '0;
      bit_q   <= '0;
      bs_q    <= 1'b0;
      done_q  <= 1'b0;
      rep_q   <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      bs_q    <= bs_d;
      done_q  <= done_d;
      rep_q   <= rep_d;
      div_q   <= div_d;
    end
  end

  assign bitstream = bs_q;
  assign BUSY      = busy;
  assign VALID     = busy;
  assign DONE      = done_q;

endmodule

// File: tb/tb_patgen.sv
// Testbench for patgen: per-cycle expected {bitstream,VALID,BUSY,DONE} tuples are
// queued when a step is set up and popped/compared one cycle at a time.
// Honours PATGEN_PARITY_EN so the expected frame matches the build.
module tb_patgen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOAD = 1'b0;
  logic [7:0] PATTERN = '0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       REPEAT = 1'b0;
  logic [3:0] DIV = '0;
  logic       bitstream, VALID, BUSY, DONE;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [3:0] exp_q[$];

  patgen #(.WIDTH(8), .DIV_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LOAD      (LOAD),
    .PATTERN   (PATTERN),
    .START     (START),
    .STOP      (STOP),
    .REPEAT    (REPEAT),
    .DIV       (DIV),
    .bitstream (bitstream),
    .VALID     (VALID),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e);
    chk({tag, ".bitstream"}, bitstream, e[3]);
    chk({tag, ".VALID"},     VALID,     e[2]);
    chk({tag, ".BUSY"},      BUSY,      e[1]);
    chk({tag, ".DONE"},      DONE,      e[0]);
  endtask

  task automatic push(input logic bs, input logic v, input logic b, input logic d);
    exp_q.push_back({bs, v, b, d});
  endtask

  // One frame as seen on the outputs: each bit MSB first held div+1 cycles.
  task automatic push_frame(input logic [7:0] pat, input int div);
    for (int i = 7; i >= 0; i--)
      for (int k = 0; k <= div; k++) push(pat[i], 1'b1, 1'b1, 1'b0);
`ifdef PATGEN_PARITY_EN
    for (int k = 0; k <= div; k++) push(^pat, 1'b1, 1'b1, 1'b0);
`endif
  endtask

  // Advance one clock, compare the next queued tuple, then drop one-cycle pulses.
  task automatic cyc(input string tag);
    logic [3:0] e;
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk_all(tag, e);
    end
    LOAD  = 1'b0;
    START = 1'b0;
    STOP  = 1'b0;
  endtask

  task automatic run_all(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      cyc(tag);
      guard++;
    end
  endtask

  initial begin
    // Reset state.
    #1;
    chk_all("reset", 4'b0000);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // One-shot, DIV=0.
    LOAD = 1'b1; PATTERN = 8'b10001101; START = 1'b1; DIV = 4'd0; REPEAT = 1'b0;
    push_frame(8'b10001101, 0);
    push(0, 0, 0, 1);
    push(0, 0, 0, 0);
    run_all("oneshot_div0");

    // One-shot, DIV=2: each bit held three cycles.
    START = 1'b1; DIV = 4'd2;
    push_frame(8'b10001101, 2);
    push(0, 0, 0, 1);
    push(0, 0, 0, 0);
    run_all("oneshot_div2");

    // Different pattern, same-cycle LOAD+START.
    LOAD = 1'b1; PATTERN = 8'b10001100; START = 1'b1; DIV = 4'd0;
    push_frame(8'b10001100, 0);
    push(0, 0, 0, 1);
    run_all("oneshot_pat2");

    // Looping; DIV/REPEAT changes mid-frame must not matter; STOP after cycle 20.
    LOAD = 1'b1; PATTERN = 8'b10001101; START = 1'b1; DIV = 4'd0; REPEAT = 1'b1;
    push_frame(8'b10001101, 0);
    push_frame(8'b10001101, 0);
    for (int i = 7; i >= 0; i--) push(PATTERN[i], 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc("repeat");
    DIV = 4'd3; REPEAT = 1'b0;
    while (exp_q.size() > 4) cyc("repeat");
    exp_q.delete();
    STOP = 1'b1;
    push(0, 0, 0, 0);
    push(0, 0, 0, 0);
    run_all("repeat_stop");
    DIV = 4'd0;

    // STOP in IDLE has no effect.
    STOP = 1'b1;
    push(0, 0, 0, 0);
    run_all("idle_stop");

    // START and LOAD while busy are ignored; stored pattern survives.
    LOAD = 1'b1; PATTERN = 8'b10110010; START = 1'b1; DIV = 4'd1;
    push_frame(8'b10110010, 1);
    push(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc("busy_ignore");
    LOAD = 1'b1; PATTERN = 8'hFF; START = 1'b1; DIV = 4'd0;
    run_all("busy_ignore");
    START = 1'b1;
    push_frame(8'b10110010, 0);
    push(0, 0, 0, 1);
    run_all("reuse_pattern");

    // Asynchronous reset mid-frame.
    LOAD = 1'b1; PATTERN = 8'b11110000; START = 1'b1;
    push(1, 1, 1, 0);
    push(1, 1, 1, 0);
    push(1, 1, 1, 0);
    run_all("pre_reset");
    #2;
    RST = 1'b1;
    #1;
    chk_all("reset_async", 4'b0000);
    @(posedge CLK);
    #1;
    chk_all("reset_held", 4'b0000);
    RST = 1'b0;

    // Pattern register was cleared; START on the first edge after release.
    START = 1'b1; DIV = 4'd0; REPEAT = 1'b0;
    push_frame(8'h00, 0);
    push(0, 0, 0, 1);
    push(0, 0, 0, 0);
    run_all("post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
